// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and defaults for the APB requester
package apb_pkg;

    localparam int APB_AWIDTH = 4;
    localparam int APB_DWIDTH = 8;
    localparam int APB_TO_CYC = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_t;

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - 8-bit saturating PREADY wait counter with expire flag
module apb_wait_timer #(
    parameter int TO_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (clear) begin
            cnt <= 8'd0;
        end else if (enable && cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Expires on the ACCESS cycle that would be the TO_CYC-th wait cycle.
    assign expire = (cnt == 8'(TO_CYC - 1));

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - command/response stream to APB3 transfer requester
module apb_master
    import apb_pkg::*;
#(
    parameter int AWIDTH = APB_AWIDTH,
    parameter int DWIDTH = APB_DWIDTH,
    parameter int TO_CYC = APB_TO_CYC
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [DWIDTH-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [AWIDTH-1:0] PADDR,
    output logic [DWIDTH-1:0] PWDATA,
    input  logic [DWIDTH-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_state_t state;
    logic       to_expire;
    logic       accept;

    assign accept = (state == ST_IDLE) && cmd_valid;

    apb_wait_timer #(.TO_CYC(TO_CYC)) u_timer (
        .clk    (PCLK),
        .rst_n  (PRESETn),
        .clear  (accept),
        .enable ((state == ST_ACCESS) && !PREADY),
        .expire (to_expire)
    );

    // PADDR/PWRITE/PWDATA double as the command latch and hold while idle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        PWRITE    <= cmd_write;
                        PADDR     <= cmd_addr;
                        PWDATA    <= cmd_wdata;
                        PSEL      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // A late PREADY on the expiring cycle still wins over the timeout.
                    if (PREADY) begin
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        rsp_err   <= PSLVERR;
                        rsp_valid <= 1'b1;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state     <= ST_RESP;
                    end else if (to_expire) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
